// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order reorder buffer for the register-file rename/commit path.
// Dispatch allocates tags at the tail and publishes each new destination dependency to
// the register file. Execution units complete entries out of order, and entries retire
// in order from the head as a (regid, value, tag) broadcast. When a mispredicted branch
// commits, the buffer empties, the RF dependencies are cleared and fetch is redirected.
// Optional feature macro: ROB_FWD_EN. When it is defined, the operand query also sees a
// writeback in the same cycle. When it is undefined, the query sees registered state only.
module rob_commit_unit #(
    parameter int ROB_ADDR = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    input  logic                issue_is_br,
    output logic                issue_accept,
    output logic [ROB_ADDR-1:0] issue_tag,
    input  logic                wb_valid,
    input  logic [ROB_ADDR-1:0] wb_tag,
    input  logic [31:0]         wb_value,
    input  logic                wb_mispred,
    input  logic [31:0]         wb_target,
    input  logic [ROB_ADDR-1:0] q1_tag,
    input  logic [ROB_ADDR-1:0] q2_tag,
    output logic                q1_ready,
    output logic                q2_ready,
    output logic [31:0]         q1_value,
    output logic [31:0]         q2_value,
    output logic [4:0]          rf_index,
    output logic [ROB_ADDR-1:0] rf_new_dep,
    output logic [4:0]          rf_commit_regid,
    output logic [31:0]         rf_commit_value,
    output logic [ROB_ADDR-1:0] rf_commit_tag,
    output logic                rf_clear,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc
);

    localparam int DEPTH = 1 << ROB_ADDR;
    localparam logic [ROB_ADDR:0] DEPTH_CNT = (ROB_ADDR+1)'(DEPTH);

    // Pointer, occupancy and flush state
    logic [ROB_ADDR-1:0] head_q, head_d;
    logic [ROB_ADDR-1:0] tail_q, tail_d;
    logic [ROB_ADDR:0]   count_q, count_d;
    logic                flush_pending_q, flush_pending_d;
    logic                rf_clear_q, rf_clear_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;

    // Per-entry state, gathered into arrays so it can be indexed by tag
    logic [DEPTH-1:0] busy_arr;
    logic [DEPTH-1:0] ready_arr;
    logic [DEPTH-1:0] is_br_arr;
    logic [DEPTH-1:0] mispred_arr;
    logic [4:0]       rd_arr     [DEPTH];
    logic [31:0]      value_arr  [DEPTH];
    logic [31:0]      target_arr [DEPTH];

    logic active;
    logic issue_fire;
    logic commit_fire;
    logic mispred_fire;
    logic wb_fire;

    // Decide this cycle's issue, commit, writeback and flush events
    always_comb begin
        active       = rdy_in & ~rst_in;
        issue_fire   = active & issue_valid & (count_q < DEPTH_CNT)
                       & ~flush_pending_q & ~rf_clear_q;
        commit_fire  = active & busy_arr[head_q] & ready_arr[head_q] & ~flush_pending_q;
        mispred_fire = commit_fire & is_br_arr[head_q] & mispred_arr[head_q];
        // Writebacks to empty slots or during the clear pulse are dropped
        wb_fire      = active & wb_valid & busy_arr[wb_tag] & ~rf_clear_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic        busy_q;
            logic        ready_q;
            logic        is_br_q;
            logic        mispred_q;
            logic [4:0]  rd_q;
            logic [31:0] value_q;
            logic [31:0] target_q;
            logic        sel_wb;
            logic        sel_commit;
            logic        sel_issue;

            assign sel_wb     = wb_fire     & (wb_tag == ROB_ADDR'(gi));
            assign sel_commit = commit_fire & (head_q == ROB_ADDR'(gi));
            assign sel_issue  = issue_fire  & (tail_q == ROB_ADDR'(gi));

            // Entry update: a flush wins. Otherwise the order is writeback, then retire,
            // then allocate, so a fresh allocation always starts as not ready.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b0;
                    is_br_q   <= 1'b0;
                    mispred_q <= 1'b0;
                    rd_q      <= 5'd0;
                    value_q   <= 32'd0;
                    target_q  <= 32'd0;
                end else if (rdy_in) begin
                    if (mispred_fire) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        if (sel_wb) begin
                            ready_q   <= 1'b1;
                            value_q   <= wb_value;
                            mispred_q <= wb_mispred;
                            target_q  <= wb_target;
                        end
                        if (sel_commit) begin
                            busy_q <= 1'b0;
                        end
                        if (sel_issue) begin
                            busy_q    <= 1'b1;
                            ready_q   <= 1'b0;
                            is_br_q   <= issue_is_br;
                            mispred_q <= 1'b0;
                            rd_q      <= issue_rd;
                        end
                    end
                end
            end

            assign busy_arr[gi]    = busy_q;
            assign ready_arr[gi]   = ready_q;
            assign is_br_arr[gi]   = is_br_q;
            assign mispred_arr[gi] = mispred_q;
            assign rd_arr[gi]      = rd_q;
            assign value_arr[gi]   = value_q;
            assign target_arr[gi]  = target_q;
        end
    endgenerate

    // Next-state for pointers, occupancy and the one-cycle flush pulse
    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        flush_pending_d  = flush_pending_q;
        rf_clear_d       = rf_clear_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        if (rdy_in) begin
            if (mispred_fire) begin
                head_d           = '0;
                tail_d           = '0;
                count_d          = '0;
                flush_pending_d  = 1'b1;
                rf_clear_d       = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target_arr[head_q];
            end else begin
                flush_pending_d  = 1'b0;
                rf_clear_d       = 1'b0;
                redirect_valid_d = 1'b0;
                if (commit_fire) head_d = head_q + 1'b1;
                if (issue_fire)  tail_d = tail_q + 1'b1;
                case ({issue_fire, commit_fire})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Register control state; reset overrides everything, including a pending flush
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            flush_pending_q  <= 1'b0;
            rf_clear_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            flush_pending_q  <= flush_pending_d;
            rf_clear_q       <= rf_clear_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Drive the issue, rename and commit outputs
    always_comb begin
        issue_accept    = issue_fire;
        issue_tag       = tail_q;
        rf_new_dep      = tail_q;
        rf_index        = issue_fire ? issue_rd : 5'd0;
        rf_commit_regid = commit_fire ? rd_arr[head_q] : 5'd0;
        rf_commit_value = value_arr[head_q];
        rf_commit_tag   = head_q;
        rf_clear        = rf_clear_q;
        redirect_valid  = redirect_valid_q;
        redirect_pc     = redirect_pc_q;
    end

`ifdef ROB_FWD_EN
    logic q1_fwd;
    logic q2_fwd;

    // Operand lookup that also forwards a same-cycle writeback
    always_comb begin
        q1_fwd   = wb_valid & ~rf_clear_q & (wb_tag == q1_tag) & busy_arr[q1_tag];
        q2_fwd   = wb_valid & ~rf_clear_q & (wb_tag == q2_tag) & busy_arr[q2_tag];
        q1_ready = busy_arr[q1_tag] & (ready_arr[q1_tag] | q1_fwd);
        q2_ready = busy_arr[q2_tag] & (ready_arr[q2_tag] | q2_fwd);
        q1_value = q1_fwd ? wb_value : value_arr[q1_tag];
        q2_value = q2_fwd ? wb_value : value_arr[q2_tag];
    end
`else
    // Operand lookup from registered entry state only
    always_comb begin
        q1_ready = busy_arr[q1_tag] & ready_arr[q1_tag];
        q2_ready = busy_arr[q2_tag] & ready_arr[q2_tag];
        q1_value = value_arr[q1_tag];
        q2_value = value_arr[q2_tag];
    end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit. The reference model keeps the buffer as a program-order
// queue of in-flight instructions. The stimulus is a few directed scenarios followed by
// random traffic.
module tb_rob_commit_unit;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_valid, issue_is_br, issue_accept;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        wb_valid, wb_mispred;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value, wb_target;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic [4:0]  rf_index, rf_commit_regid;
    logic [3:0]  rf_new_dep, rf_commit_tag;
    logic [31:0] rf_commit_value, redirect_pc;
    logic        rf_clear, redirect_valid;

    rob_commit_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .issue_accept(issue_accept), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispred(wb_mispred), .wb_target(wb_target),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .rf_index(rf_index), .rf_new_dep(rf_new_dep),
        .rf_commit_regid(rf_commit_regid), .rf_commit_value(rf_commit_value),
        .rf_commit_tag(rf_commit_tag), .rf_clear(rf_clear),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int        tag;
        int        rd;
        bit        is_br;
        bit        done;
        bit [31:0] value;
        bit        mis;
        bit [31:0] tgt;
    } ent_t;

    ent_t      rob_m[$];
    int        next_tag_m;
    bit        flush_m;
    bit [31:0] rpc_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int find_tag(input int tag);
        for (int i = 0; i < rob_m.size(); i++)
            if (rob_m[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic query_check(input string nm, input int qt, input bit wbv, input int wbt,
                               input bit [31:0] wbval, input logic rdy_got,
                               input logic [31:0] val_got);
        int  idx;
        bit  er;
        bit  fwd;
        bit [31:0] ev;
        idx = find_tag(qt);
        fwd = 1'b0;
`ifdef ROB_FWD_EN
        fwd = (idx >= 0) && wbv && (wbt == qt) && !flush_m;
`endif
        er = (idx >= 0) && (rob_m[idx].done || fwd);
        ev = fwd ? wbval : ((idx >= 0) ? rob_m[idx].value : 32'd0);
        chk({nm, "_ready"}, rdy_got, er);
        if (er) chk({nm, "_value"}, val_got, ev);
    endtask

    // One clock cycle: drive inputs, check combinational/registered outputs against the
    // model, then advance the model at the clock edge
    task automatic cycle(input bit rdy, input bit v, input int rd, input bit br,
                         input bit wbv, input int wbt, input bit [31:0] wbval,
                         input bit wbm, input bit [31:0] wbtgt, input int q1, input int q2);
        bit acc, cm, mp;
        bit [31:0] mp_tgt;
        int idx;
        ent_t e;
        @(negedge clk_in);
        rst_in = 1'b0; rdy_in = rdy;
        issue_valid = v; issue_rd = rd[4:0]; issue_is_br = br;
        wb_valid = wbv; wb_tag = wbt[3:0]; wb_value = wbval;
        wb_mispred = wbm; wb_target = wbtgt;
        q1_tag = q1[3:0]; q2_tag = q2[3:0];
        #1;
        acc = rdy && v && (rob_m.size() < 16) && !flush_m;
        cm  = rdy && !flush_m && (rob_m.size() > 0) && rob_m[0].done;
        chk("issue_accept", issue_accept, acc);
        if (acc) begin
            chk("issue_tag", issue_tag, next_tag_m);
            chk("rf_new_dep", rf_new_dep, next_tag_m);
        end
        chk("rf_index", rf_index, acc ? rd : 0);
        chk("commit_regid", rf_commit_regid, cm ? rob_m[0].rd : 0);
        if (cm) begin
            chk("commit_value", rf_commit_value, rob_m[0].value);
            chk("commit_tag", rf_commit_tag, rob_m[0].tag);
        end
        chk("rf_clear", rf_clear, flush_m);
        chk("redirect_valid", redirect_valid, flush_m);
        chk("redirect_pc", redirect_pc, rpc_m);
        query_check("q1", q1, wbv, wbt, wbval, q1_ready, q1_value);
        query_check("q2", q2, wbv, wbt, wbval, q2_ready, q2_value);
        @(posedge clk_in);
        if (rdy) begin
            mp     = cm && rob_m[0].is_br && rob_m[0].mis;
            mp_tgt = cm ? rob_m[0].tgt : 32'd0;
            if (wbv && !flush_m) begin
                idx = find_tag(wbt);
                if (idx >= 0) begin
                    rob_m[idx].done  = 1'b1;
                    rob_m[idx].value = wbval;
                    rob_m[idx].mis   = wbm;
                    rob_m[idx].tgt   = wbtgt;
                end
            end
            if (mp) begin
                rob_m.delete();
                next_tag_m = 0;
                flush_m    = 1'b1;
                rpc_m      = mp_tgt;
            end else begin
                flush_m = 1'b0;
                if (cm) void'(rob_m.pop_front());
                if (acc) begin
                    e = '{tag: next_tag_m, rd: rd, is_br: br, done: 1'b0,
                          value: 32'd0, mis: 1'b0, tgt: 32'd0};
                    rob_m.push_back(e);
                    next_tag_m = (next_tag_m + 1) % 16;
                end
            end
        end
    endtask

    task automatic do_issue(input int rd, input bit br);
        cycle(1, 1, rd, br, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_wb(input int tag, input bit [31:0] val, input bit mis, input bit [31:0] tgt);
        cycle(1, 0, 0, 0, 1, tag, val, mis, tgt, tag, 0);
    endtask

    task automatic do_idle(input int q1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
    endtask

    // Hold reset with an active issue offer and check the reset-state outputs
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b1; issue_valid = 1'b1; issue_rd = 5'd7;
        wb_valid = 1'b0; q1_tag = 4'd0; q2_tag = 4'd0;
        @(negedge clk_in);
        #1;
        chk("rst_accept", issue_accept, 0);
        chk("rst_rf_index", rf_index, 0);
        chk("rst_commit_regid", rf_commit_regid, 0);
        chk("rst_rf_clear", rf_clear, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_q1_ready", q1_ready, 0);
        rob_m.delete();
        next_tag_m = 0;
        flush_m    = 1'b0;
        rpc_m      = 32'd0;
    endtask

    initial begin
        int        rd, wbt, idx, q1, q2;
        bit        rdy, v, br, wbv, wbm;
        bit [31:0] wbval;
        int        wb_pct;

        rst_in = 1'b1; rdy_in = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
        issue_is_br = 1'b0; wb_valid = 1'b0; wb_tag = 4'd0; wb_value = 32'd0;
        wb_mispred = 1'b0; wb_target = 32'd0; q1_tag = 4'd0; q2_tag = 4'd0;

        // Issue, then writeback and in-order commit
        do_reset();
        do_issue(5, 0);
        do_wb(0, 32'h1234, 0, 0);
        do_idle(0);

        // Fill to capacity, reject the 17th, then retire one and reuse tag 0
        do_reset();
        for (int i = 0; i < 17; i++) do_issue(i % 32, 0);
        do_wb(0, 32'h55, 0, 0);
        do_issue(9, 0);
        do_issue(9, 0);

        // Out-of-order completion retires in order
        do_reset();
        do_issue(2, 0);
        do_issue(3, 0);
        do_wb(1, 32'hB1, 0, 0);
        do_idle(1);
        do_wb(0, 32'hB0, 0, 0);
        do_idle(0);
        do_idle(1);

        // Mispredicted branch with younger entries: link commit, flush pulse, empty buffer
        do_reset();
        do_issue(1, 1);
        for (int i = 0; i < 3; i++) do_issue(4 + i, 0);
        do_wb(0, 32'h44, 1, 32'h100);
        do_idle(0);
        do_issue(8, 0);
        do_issue(9, 0);

        // Same-cycle writeback seen by the operand query (forwarded only with the feature)
        do_reset();
        for (int i = 0; i < 3; i++) do_issue(10 + i, 0);
        cycle(1, 0, 0, 0, 1, 2, 32'hAB, 0, 0, 2, 2);
        do_idle(2);

        // Random traffic with phases of sparse and dense completion, plus a mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            wb_pct = ((c / 200) % 2 == 0) ? 70 : 15;
            rdy = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 3) != 0);
            rd  = $urandom_range(0, 31);
            br  = ($urandom_range(0, 3) == 0);
            wbv = ($urandom_range(0, 99) < wb_pct);
            wbm = 1'b0;
            wbval = $urandom;
            if (rob_m.size() > 0 && $urandom_range(0, 9) != 0) begin
                idx = $urandom_range(0, rob_m.size() - 1);
                wbt = rob_m[idx].tag;
                wbm = rob_m[idx].is_br && ($urandom_range(0, 7) == 0);
            end else begin
                wbt = $urandom_range(0, 15);
            end
            q1 = (rob_m.size() > 0) ? rob_m[$urandom_range(0, rob_m.size() - 1)].tag
                                    : $urandom_range(0, 15);
            q2 = $urandom_range(0, 1) ? wbt : $urandom_range(0, 15);
            cycle(rdy, v, rd, br, wbv, wbt, wbval, wbm, $urandom, q1, q2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
